// File: rtl/scene_rect_writer_pkg.sv
// scene_rect_writer_pkg: scene geometry, colour width and writer state encoding shared with scan-out
package scene_rect_writer_pkg;
  localparam int SCENE_WIDTH = 400;
  localparam int SCENE_HEIGHT = 300;
  localparam int COORD_W = 9;
  localparam int COLOR_W = 6;
  localparam logic [COLOR_W-1:0] BLACK = 6'b000000;
  typedef enum logic [1:0] {IDLE, WAIT_VB, FILL, DONE} state_t;
endpackage

// File: rtl/scene_rect_writer_rect_clip.sv
// rect_clip: clips a rectangle or clear command to the scene and flags commands that write nothing
module rect_clip import scene_rect_writer_pkg::*; #(
  parameter int SCENE_WIDTH = scene_rect_writer_pkg::SCENE_WIDTH,
  parameter int SCENE_HEIGHT = scene_rect_writer_pkg::SCENE_HEIGHT,
  parameter int COORD_W = scene_rect_writer_pkg::COORD_W
) (
  input  logic               clear,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  output logic [COORD_W-1:0] x0,
  output logic [COORD_W-1:0] y0,
  output logic [COORD_W:0]   x_end,
  output logic [COORD_W:0]   y_end,
  output logic               empty
);
  localparam logic [COORD_W:0] SW = (COORD_W+1)'(SCENE_WIDTH);
  localparam logic [COORD_W:0] SH = (COORD_W+1)'(SCENE_HEIGHT);
  logic [COORD_W:0] xs, ys;
  // one extra bit on the sums so x+w and y+h never wrap before the min against the scene edge
  always_comb begin
    xs = {1'b0, x} + {1'b0, w};
    ys = {1'b0, y} + {1'b0, h};
    x0 = clear ? '0 : x;
    y0 = clear ? '0 : y;
    x_end = (clear || xs > SW) ? SW : xs;
    y_end = (clear || ys > SH) ? SH : ys;
    empty = !clear && (w == '0 || h == '0 || {1'b0, x} >= SW || {1'b0, y} >= SH);
  end
endmodule

// File: rtl/scene_rect_writer.sv
// scene_rect_writer: fills clipped rectangles / clears the scene one pixel per clock in row-major order
// Define SCENE_WRITER_VBLANK_SYNC_EN to hold each non-empty fill until the next vertical_porch_start pulse.
module scene_rect_writer import scene_rect_writer_pkg::*; #(
  parameter int SCENE_WIDTH = scene_rect_writer_pkg::SCENE_WIDTH,
  parameter int SCENE_HEIGHT = scene_rect_writer_pkg::SCENE_HEIGHT,
  parameter int COORD_W = scene_rect_writer_pkg::COORD_W
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_clear,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [COORD_W-1:0] cmd_w,
  input  logic [COORD_W-1:0] cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               vertical_porch_start,
  output logic               wr_en,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic [COLOR_W-1:0] wr_color,
  output logic               busy,
  output logic               done
);
  state_t state, state_n;
  logic [COORD_W-1:0] x0_c, y0_c, x0, x_n, y_n;
  logic [COORD_W:0] x_end_c, y_end_c, x_end, y_end, xi, yi;
  logic empty_c, accept, last_col;
  rect_clip #(.SCENE_WIDTH(SCENE_WIDTH), .SCENE_HEIGHT(SCENE_HEIGHT), .COORD_W(COORD_W)) u_clip (
    .clear(cmd_clear), .x(cmd_x), .y(cmd_y), .w(cmd_w), .h(cmd_h),
    .x0(x0_c), .y0(y0_c), .x_end(x_end_c), .y_end(y_end_c), .empty(empty_c)
  );
  assign cmd_ready = state == IDLE && !rst;
  assign accept = cmd_valid && cmd_ready;
  assign busy = state != IDLE;
`ifndef SCENE_WRITER_VBLANK_SYNC_EN
  logic vblank_unused;
  assign vblank_unused = vertical_porch_start;
`endif
  // next state and cursor; the cursor lives in wr_x/wr_y so the write port needs no extra stage
  always_comb begin
    state_n = state;
    x_n = wr_x;
    y_n = wr_y;
    xi = {1'b0, wr_x} + (COORD_W+1)'(1);
    yi = {1'b0, wr_y} + (COORD_W+1)'(1);
    last_col = xi == x_end;
    case (state)
      IDLE: if (accept) begin
        x_n = x0_c;
        y_n = y0_c;
`ifdef SCENE_WRITER_VBLANK_SYNC_EN
        state_n = empty_c ? DONE : WAIT_VB;
`else
        state_n = empty_c ? DONE : FILL;
`endif
      end
`ifdef SCENE_WRITER_VBLANK_SYNC_EN
      WAIT_VB: state_n = vertical_porch_start ? FILL : WAIT_VB;
`endif
      FILL: begin
        x_n = last_col ? x0 : xi[COORD_W-1:0];
        y_n = last_col ? yi[COORD_W-1:0] : wr_y;
        state_n = (last_col && yi == y_end) ? DONE : FILL;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, registered write port and the command fields latched on accept
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wr_en <= 1'b0;
      wr_x <= '0;
      wr_y <= '0;
      wr_color <= BLACK;
      done <= 1'b0;
      x0 <= '0;
      x_end <= '0;
      y_end <= '0;
    end else begin
      state <= state_n;
      wr_en <= state_n == FILL;
      done <= state_n == DONE;
      wr_x <= x_n;
      wr_y <= y_n;
      if (accept) begin
        x0 <= x0_c;
        x_end <= x_end_c;
        y_end <= y_end_c;
        wr_color <= cmd_color;
      end
    end
  end
endmodule

// File: tb/tb_scene_rect_writer.sv
// tb_scene_rect_writer: randomized scoreboard bench for scene_rect_writer (reduced scene height keeps the clear short)
module tb_scene_rect_writer;
  localparam int TW = 400;
  localparam int TH = 100;
`ifdef SCENE_WRITER_VBLANK_SYNC_EN
  localparam bit VB = 1'b1;
`else
  localparam bit VB = 1'b0;
`endif
  logic pixel_clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_clear = 1'b0, vertical_porch_start = 1'b0;
  logic [8:0] cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [5:0] cmd_color = '0;
  logic cmd_ready, wr_en, busy, done;
  logic [8:0] wr_x, wr_y;
  logic [5:0] wr_color;
  int cyc = 0, checks = 0, errors = 0, exp_acc = 0;
  bit have_prev = 1'b0;
  typedef struct {bit is_done; int x; int y; int c; int cyc;} ev_t;
  ev_t q[$];

  scene_rect_writer #(.SCENE_WIDTH(TW), .SCENE_HEIGHT(TH), .COORD_W(9)) dut (
    .pixel_clk(pixel_clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_clear(cmd_clear), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .vertical_porch_start(vertical_porch_start),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .busy(busy), .done(done)
  );

  always #5 pixel_clk = ~pixel_clk;
  always @(posedge pixel_clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // monitor: every write or done pulse must match the oldest expected event, on its expected cycle
  always @(negedge pixel_clk) begin
    ev_t e;
    if (!rst) begin
      if (wr_en || done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output wr_en=%0b done=%0b x=%0d y=%0d cycle %0d", wr_en, done, wr_x, wr_y, cyc);
        end else begin
          e = q.pop_front();
          chk("event_kind_done", 32'(done), 32'(e.is_done));
          chk("event_cycle", cyc, e.cyc);
          chk("busy_during_cmd", 32'(busy), 1);
          if (!e.is_done) begin
            chk("wr_x", 32'(wr_x), e.x);
            chk("wr_y", 32'(wr_y), e.y);
            chk("wr_color", 32'(wr_color), e.c);
          end else chk("wr_en_at_done", 32'(wr_en), 0);
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_event done=%0b x=%0d y=%0d expected at cycle %0d now %0d", e.is_done, e.x, e.y, e.cyc, cyc);
      end
    end
  end

  // issue one command (valid stays high afterwards) and push the reference model's events
  task automatic send(input bit clr, input int x, input int y, input int w, input int h,
                      input int c, input int d, input int trunc);
    int k, e, f, n, x0, y0, xe, ye, i;
    bit emp;
    cmd_valid = 1'b1;
    cmd_clear = clr;
    cmd_x = 9'(x);
    cmd_y = 9'(y);
    cmd_w = 9'(w);
    cmd_h = 9'(h);
    cmd_color = 6'(c);
    k = 0;
    while (!cmd_ready && k < 60000) begin
      @(negedge pixel_clk);
      k++;
    end
    if (!cmd_ready) begin
      $display("FAIL accept_timeout waited %0d cycles", k);
      $fatal(1);
    end
    e = cyc + 1;
    if (have_prev) chk("accept_cycle", e, exp_acc);
    vertical_porch_start = 1'b1;
    if (clr) begin
      x0 = 0; y0 = 0; xe = TW; ye = TH; emp = 1'b0;
    end else begin
      x0 = x; y0 = y;
      xe = (x + w < TW) ? x + w : TW;
      ye = (y + h < TH) ? y + h : TH;
      emp = (w == 0 || h == 0 || x >= TW || y >= TH);
    end
    n = emp ? 0 : (xe - x0) * (ye - y0);
    f = e;
    if (VB && !emp) begin
      @(negedge pixel_clk);
      vertical_porch_start = 1'b0;
      repeat (d - 1) @(negedge pixel_clk);
      vertical_porch_start = 1'b1;
      f = cyc + 1;
    end
    i = 0;
    for (int yy = y0; yy < ye && !emp; yy++)
      for (int xx = x0; xx < xe; xx++) begin
        if (trunc < 0 || i < trunc) q.push_back('{1'b0, xx, yy, c, f + i});
        i++;
      end
    if (trunc < 0) q.push_back('{1'b1, 0, 0, 0, f + n});
    @(negedge pixel_clk);
    vertical_porch_start = 1'b0;
    exp_acc = f + n + 2;
    have_prev = 1'b1;
  endtask

  initial begin
    int k;
    repeat (3) @(negedge pixel_clk);
    chk("reset_wr_en", 32'(wr_en), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_wr_x", 32'(wr_x), 0);
    chk("reset_wr_color", 32'(wr_color), 0);
    rst = 1'b0;
    #1 chk("ready_after_reset", 32'(cmd_ready), 1);
    @(negedge pixel_clk);
    send(0, 10, 20, 2, 1, 'h3C, 50, -1);
    send(0, 10, 20, 4, 3, 'h2A, 5, -1);
    send(0, 398, TH - 2, 5, 5, 'h11, 3, -1);
    send(0, 10, 20, 0, 3, 'h07, 3, -1);
    send(0, 450, 20, 4, 3, 'h07, 3, -1);
    send(0, 10, TH + 5, 4, 3, 'h07, 3, -1);
    for (int i = 0; i < 40; i++)
      send(0, $urandom_range(0, 1) ? $urandom_range(TW - 8, TW + 3) : $urandom_range(0, TW),
           $urandom_range(0, TH + 10), $urandom_range(0, 12), $urandom_range(0, 5),
           $urandom_range(0, 63), $urandom_range(2, 20), -1);
    send(1, 77, 88, 99, 11, 0, 4, -1);
    send(0, 5, 6, 3, 2, 'h3F, 4, -1);
    send(0, 10, 20, 4, 3, 'h15, 6, 4);
    repeat (4) @(posedge pixel_clk);
    #1 rst = 1'b1;
    cmd_valid = 1'b0;
    #1 chk("rst_mid_fill_wr_en", 32'(wr_en), 0);
    chk("rst_mid_fill_busy", 32'(busy), 0);
    chk("rst_mid_fill_done", 32'(done), 0);
    @(negedge pixel_clk);
    @(negedge pixel_clk);
    rst = 1'b0;
    have_prev = 1'b0;
    #1 chk("ready_after_mid_reset", 32'(cmd_ready), 1);
    repeat (20) @(negedge pixel_clk);
    send(0, 0, 0, 3, 2, 'h24, 3, -1);
    cmd_valid = 1'b0;
    k = 0;
    while (q.size() > 0 && k < 2000) begin
      @(negedge pixel_clk);
      k++;
    end
    repeat (5) @(negedge pixel_clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scene_rect_writer.md
Name: scene_rect_writer

Overview:
- Writer side of the 400x300 logical-pixel scene buffer that the display controller reads during scan-out.
- Accepts rectangle-fill and clear commands over a valid/ready handshake.
- Writes one 6-bit RRGGBB pixel per clock into the scene buffer write port, in row-major order, clipped to the scene.
- Sits between the game logic (player, platform and background drawing) and the dual-port scene memory.

Parameters:
- SCENE_WIDTH, 400, logical scene width in pixels.
- SCENE_HEIGHT, 300, logical scene height in pixels.
- COORD_W, 9, width of the coordinate and size fields.

Ports:
- pixel_clk  in  1  system clock; same clock as scan-out.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_clear  in  1  1 = clear the whole scene; x/y/w/h are ignored.
- cmd_x  in  9  rectangle left column.
- cmd_y  in  9  rectangle top row.
- cmd_w  in  9  rectangle width.
- cmd_h  in  9  rectangle height.
- cmd_color  in  6  fill colour, RRGGBB.
- vertical_porch_start  in  1  one-cycle pulse from scan-out at the start of vertical blanking.
- wr_en  out  1  scene memory write strobe.
- wr_x  out  9  write column.
- wr_y  out  9  write row.
- wr_color  out  6  write data.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse after the last pixel of a command.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; wr_en=0, wr_x=0, wr_y=0, wr_color=0, busy=0, done=0; cmd_ready=1 once rst deasserts.
  - A command in flight is abandoned; no further writes occur.
- Handshake:
  - cmd_ready=1 only in IDLE.
  - A command is accepted on a cycle where cmd_valid & cmd_ready.
  - cmd_* fields are sampled only on that cycle; later changes are ignored.
- Clipping, computed at accept time in 10-bit arithmetic (no overflow):
  - x_end = min(cmd_x + cmd_w, SCENE_WIDTH)
  - y_end = min(cmd_y + cmd_h, SCENE_HEIGHT)
  - Clear: x0=0, y0=0, x_end=400, y_end=300.
  - Empty rectangle (cmd_w=0, cmd_h=0, cmd_x>=400, or cmd_y>=300): no writes. Go to DONE on the next cycle.
- States:
  - IDLE: wait for accept. Non-empty command -> FILL (or WAIT_VB, see Optional Feature). Empty command -> DONE.
  - FILL: every cycle drive wr_en=1 with wr_x/wr_y = current cursor and wr_color = latched colour.
    - Advance x. When x+1 == x_end: x <= x0, y <= y+1.
    - Last pixel (x_end-1, y_end-1) -> DONE.
  - DONE: wr_en=0, done=1 for one cycle, then IDLE.
- Outputs:
  - busy=1 in every state except IDLE.
  - wr_en is registered. First write appears on the cycle after accept.
  - A command of N pixels occupies exactly N FILL cycles.
- Throughput: one command per N+2 cycles (accept, N writes, DONE).
- Scan-out interaction: vertical_porch_start is ignored unless the optional feature is enabled. Writes may collide with scan-out reads; tearing is tolerated without the feature.

Optional Feature:
- Macro: SCENE_WRITER_VBLANK_SYNC_EN.
- Defined:
  - An accepted non-empty command enters WAIT_VB and holds wr_en=0 until vertical_porch_start is seen, then goes to FILL on the next cycle.
  - A pulse coinciding with the accept cycle is not used; the block waits for the next pulse.
  - Empty commands skip WAIT_VB.
- Undefined: WAIT_VB does not exist; behaviour is exactly as above.

Decomposition:
- Shared package holds SCENE_WIDTH=400, SCENE_HEIGHT=300, the colour width (6), the state encoding (IDLE, WAIT_VB, FILL, DONE) and a colour constant BLACK=6'b000000.
- The scan-out controller uses the same constants.
- One sub-module is natural: rect_clip, a combinational block that produces x0, y0, x_end, y_end and an empty flag from the command fields.

Test Plan:
- Reset mid-FILL:
  - Accept a rect x=10, y=20, w=4, h=3; assert rst during the 5th write.
  - Expect wr_en=0 asynchronously, busy=0, cmd_ready=1 after release, and no further writes.
- Basic fill:
  - Rect x=10, y=20, w=4, h=3, colour 6'h2A.
  - Expect 12 writes in order (10,20)..(13,20),(10,21)..(13,22), all with colour 2A.
  - First write 1 cycle after accept; done pulses 1 cycle after the last write.
- Clip:
  - Rect x=398, y=298, w=5, h=5.
  - Expect exactly 4 writes: (398,298),(399,298),(398,299),(399,299).
- Empty:
  - w=0, then x=450.
  - Expect no wr_en, done 1 cycle after accept, cmd_ready again the following cycle.
- Clear:
  - cmd_clear=1, colour 0.
  - Expect 120000 writes; the last is (399,299); busy is held throughout.
  - cmd_valid held high with a second command: it is accepted only after done.
- VBLANK sync (macro defined):
  - Accept a rect w=2, h=1, pulse vertical_porch_start 50 cycles later.
  - Expect zero writes before the pulse and the first write on the cycle after it.
